ahb_slave_port_arbiter: RTL and testbench
=========================================

Name: ahb_slave_port_arbiter

Overview:
Per-slave arbitration controller for the multi-master AHB interconnect. There is one instance per slave port. It decides which master owns that slave's address phase. It tracks the data-phase owner so the interconnect can route hwdata, hrdata, hresp and hready. It supports round-robin fairness, burst hold and hmastlock-locked sequences. A lock-timeout monitor flags runaway locked sequences.

Parameters:
NO_OF_MASTERS, 4, number of requesting masters (>=1)
LOCK_TIMEOUT, 256, cycles in LOCK state before lock_err pulses (>=2)
MW (localparam), max(1,$clog2(NO_OF_MASTERS)), master-index width

Ports:
hclk  input  1  AHB clock
hresetn  input  1  synchronous active-low reset, sampled on rising hclk
m_htrans  input  2*NO_OF_MASTERS  per-master htrans; master m occupies bits [2m+1:2m]
m_hsel  input  NO_OF_MASTERS  master m's address decodes to this slave
m_hmastlock  input  NO_OF_MASTERS  per-master hmastlock
s_hreadyout  input  1  slave hreadyout; all ownership changes are qualified by it
grant  output  NO_OF_MASTERS  one-hot address-phase owner; all zero when grant_valid=0
grant_id  output  MW  binary index of the address-phase owner
grant_valid  output  1  an owner exists
dp_valid  output  1  a data phase is in progress for dp_owner
dp_owner  output  MW  master owning the current data phase
locked  output  1  arbiter is in LOCK state
lock_err  output  1  one-cycle pulse when the lock timeout is reached

Behaviour:
- Request: req[m] = m_hsel[m] && m_htrans[m] is NONSEQ (10) or SEQ (11). IDLE (00) and BUSY (01) are not new requests.
- Reset: all outputs are registered and reset to 0. This covers grant, grant_id, grant_valid, dp_valid, dp_owner, locked and lock_err. rr_ptr=0, lock counter=0, state=ARB_IDLE. Reset overrides s_hreadyout.
- Stall: when s_hreadyout=0, state, grant*, dp_*, rr_ptr and the lock counter all hold. The exception is lock_err, which clears after its pulse.
- Pick function: choose the first requester scanning rr_ptr, rr_ptr+1, … mod NO_OF_MASTERS. Requesters with hmastlock=1 take priority over all unlocked requesters. Scan order is the same within each class.
- State machine (evaluated on the edge where s_hreadyout=1):
  ARB_IDLE: if no req, stay. Otherwise grant pick(). Go to ARB_LOCK if the winner's hmastlock=1, else ARB_OWN.
  ARB_OWN: if the owner's htrans is SEQ or BUSY, hold owner (burst continuation). Else if the owner's hmastlock=1, go to ARB_LOCK and hold. Otherwise re-arbitrate among all req (the owner included), and go to ARB_IDLE if there is none.
  ARB_LOCK: hold the owner while the owner's hmastlock=1, regardless of htrans. When hmastlock=0, apply the ARB_OWN rules in the same edge.
- Handover: when an owner releases while others request, the new grant takes effect on the same edge. There is no idle gap.
- Grant latency: a request is granted one edge later at the earliest (registered grant). Until then the interconnect keeps the master's hready low.
- rr_ptr: on every edge where a new owner is selected (an owner change, or a grant from ARB_IDLE), rr_ptr <= (winner+1) mod NO_OF_MASTERS. rr_ptr is unchanged while an owner is held.
- Data phase: on an edge with s_hreadyout=1, dp_valid <= grant_valid && req[grant_id] and dp_owner <= grant_id. This is the address-to-data pipeline step.
- Lock timeout: the counter increments each cycle in ARB_LOCK with s_hreadyout=1. It clears on leaving ARB_LOCK. lock_err pulses for one cycle when count reaches LOCK_TIMEOUT-1. The counter then saturates with no further pulses, and the lock is still honoured.
- NO_OF_MASTERS=1: the single master is always the pick, and rr_ptr stays 0.
- grant is always one-hot or zero and always equals the decode of grant_id gated by grant_valid.

Test Plan:
- Reset with m0 requesting -> all outputs 0. After hresetn rises, the next edge gives grant=0001, grant_id=0, state OWN; one edge later dp_valid=1, dp_owner=0.
- m0 and m2 both issue NONSEQ single transfers repeatedly with s_hreadyout=1 -> grant alternates 0001, 0100, 0001, …; rr_ptr=1 after the m0 grant and 3 after the m2 grant.
- m1 runs a 4-beat INCR4 (NONSEQ, SEQ, SEQ, SEQ) while m3 requests -> m1 is held for 4 accepted beats, and m3 is granted on the edge after the last SEQ with no gap.
- s_hreadyout=0 for 3 cycles during m1's data phase while m2 requests -> grant, dp_owner and rr_ptr are frozen for the 3 cycles; the handover occurs only on a ready edge.
- m2 asserts hmastlock and issues transfers while m0 and m1 request -> locked=1, m2 is held. With LOCK_TIMEOUT=8, lock_err is high for exactly one cycle after 8 locked ready cycles; when m2 drops hmastlock, m0 is granted.
- hresetn driven low mid-burst -> at the next edge all outputs are 0 and state is ARB_IDLE. After release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/ahb_slave_port_arbiter.sv
// ahb_slave_port_arbiter
// Per-slave arbitration controller for a multi-master AHB interconnect.
// Selects the address-phase owner of one slave port (round-robin, with
// priority for hmastlock requesters) and follows that owner into the data
// phase so the interconnect can route hwdata/hrdata/hresp/hready.
// A locked owner is honoured indefinitely. lock_err only reports a locked
// sequence that has run for LOCK_TIMEOUT ready cycles.
module ahb_slave_port_arbiter #(
    parameter int NO_OF_MASTERS = 4,
    parameter int LOCK_TIMEOUT  = 256,
    localparam int MW = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1
) (
    input  logic                         hclk,
    input  logic                         hresetn,
    input  logic [2*NO_OF_MASTERS-1:0]   m_htrans,
    input  logic [NO_OF_MASTERS-1:0]     m_hsel,
    input  logic [NO_OF_MASTERS-1:0]     m_hmastlock,
    input  logic                         s_hreadyout,
    output logic [NO_OF_MASTERS-1:0]     grant,
    output logic [MW-1:0]                grant_id,
    output logic                         grant_valid,
    output logic                         dp_valid,
    output logic [MW-1:0]                dp_owner,
    output logic                         locked,
    output logic                         lock_err
);

    // Counter must be able to hold LOCK_TIMEOUT itself; that value marks saturation.
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(LOCK_TIMEOUT);
    localparam logic [MW-1:0] IDX_ONE  = MW'(1);
    localparam logic [MW-1:0] IDX_LAST = MW'(NO_OF_MASTERS - 1);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_OWN  = 2'b01,
        ARB_LOCK = 2'b10
    } arb_state_t;

    arb_state_t                 state_r, state_s;
    logic [NO_OF_MASTERS-1:0]   req_s, lreq_s, grant_r, grant_s;
    logic [MW-1:0]              grant_id_r, grant_id_s;
    logic [MW-1:0]              dp_owner_r, dp_owner_s;
    logic [MW-1:0]              rr_ptr_r, rr_ptr_s;
    logic [MW-1:0]              win_s, win_next_ptr_s;
    logic                       grant_valid_r, grant_valid_s;
    logic                       dp_valid_r, dp_valid_s;
    logic                       locked_r;
    logic                       lock_err_r, lock_err_s;
    logic [CW-1:0]              lock_cnt_r, lock_cnt_s;
    logic                       any_req_s, any_lreq_s, win_lock_s;
    logic [1:0]                 owner_htrans_s;
    logic                       owner_lock_s, owner_req_s, owner_cont_s;
    logic                       do_arb_s;

    // First set bit of vec when scanning ptr, ptr+1, ... modulo NO_OF_MASTERS.
    function automatic logic [MW-1:0] pick_first(input logic [NO_OF_MASTERS-1:0] vec,
                                                 input logic [MW-1:0] ptr);
        logic [MW-1:0] res;
        logic          found;
        int            idx;
        res   = {MW{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NO_OF_MASTERS; i++) begin
            idx = (int'(ptr) + i) % NO_OF_MASTERS;
            if (!found && vec[idx[MW-1:0]]) begin
                res   = idx[MW-1:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

    // Request decode: only NONSEQ/SEQ (htrans[1]=1) on a selected master counts.
    always_comb begin
        req_s  = {NO_OF_MASTERS{1'b0}};
        lreq_s = {NO_OF_MASTERS{1'b0}};
        for (int m = 0; m < NO_OF_MASTERS; m++) begin
            req_s[m]  = m_hsel[m] & m_htrans[2*m+1];
            lreq_s[m] = m_hsel[m] & m_htrans[2*m+1] & m_hmastlock[m];
        end
    end

    // Current owner's transfer type, lock and request, muxed by grant_id.
    always_comb begin
        owner_htrans_s = 2'b00;
        owner_lock_s   = 1'b0;
        owner_req_s    = 1'b0;
        for (int m = 0; m < NO_OF_MASTERS; m++) begin
            owner_htrans_s = owner_htrans_s |
                             ((grant_id_r == MW'(m)) ? m_htrans[2*m +: 2] : 2'b00);
            owner_lock_s   = owner_lock_s | ((grant_id_r == MW'(m)) & m_hmastlock[m]);
            owner_req_s    = owner_req_s  | ((grant_id_r == MW'(m)) & req_s[m]);
        end
        // SEQ (11) and BUSY (01) both continue a burst.
        owner_cont_s = owner_htrans_s[0];
    end

    // Winner selection: locked requesters first, same round-robin order in each class.
    always_comb begin
        any_req_s  = |req_s;
        any_lreq_s = |lreq_s;
        if (any_lreq_s) begin
            win_s = pick_first(lreq_s, rr_ptr_r);
        end else begin
            win_s = pick_first(req_s, rr_ptr_r);
        end
        win_lock_s     = lreq_s[win_s];
        win_next_ptr_s = (win_s == IDX_LAST) ? {MW{1'b0}} : (win_s + IDX_ONE);
    end

    // Next-state, ownership, lock-timeout and data-phase logic; all hold on a stall.
    always_comb begin
        state_s       = state_r;
        grant_id_s    = grant_id_r;
        grant_valid_s = grant_valid_r;
        rr_ptr_s      = rr_ptr_r;
        lock_cnt_s    = lock_cnt_r;
        lock_err_s    = 1'b0;
        dp_valid_s    = dp_valid_r;
        dp_owner_s    = dp_owner_r;
        do_arb_s      = 1'b0;
        if (s_hreadyout) begin
            case (state_r)
                ARB_IDLE: begin
                    do_arb_s = 1'b1;
                end
                ARB_OWN: begin
                    if (owner_cont_s) begin
                        state_s = ARB_OWN;
                    end else if (owner_lock_s) begin
                        state_s = ARB_LOCK;
                    end else begin
                        do_arb_s = 1'b1;
                    end
                end
                ARB_LOCK: begin
                    if (owner_lock_s) begin
                        state_s = ARB_LOCK;
                    end else if (owner_cont_s) begin
                        state_s = ARB_OWN;
                    end else begin
                        do_arb_s = 1'b1;
                    end
                end
                default: begin
                    do_arb_s = 1'b1;
                end
            endcase

            if (do_arb_s) begin
                if (any_req_s) begin
                    grant_id_s    = win_s;
                    grant_valid_s = 1'b1;
                    rr_ptr_s      = win_next_ptr_s;
                    state_s       = win_lock_s ? ARB_LOCK : ARB_OWN;
                end else begin
                    grant_id_s    = {MW{1'b0}};
                    grant_valid_s = 1'b0;
                    state_s       = ARB_IDLE;
                end
            end else begin
                grant_valid_s = grant_valid_r;
            end

            // Count ready cycles spent locked; pulse once, then saturate silently.
            if ((state_r == ARB_LOCK) && (state_s == ARB_LOCK)) begin
                lock_err_s = (lock_cnt_r == CNT_LAST);
                if (lock_cnt_r != CNT_SAT) begin
                    lock_cnt_s = lock_cnt_r + CNT_ONE;
                end else begin
                    lock_cnt_s = lock_cnt_r;
                end
            end else begin
                lock_cnt_s = {CW{1'b0}};
            end

            // Address-to-data pipeline step.
            dp_valid_s = grant_valid_r & owner_req_s;
            dp_owner_s = grant_id_r;
        end else begin
            lock_err_s = 1'b0;
        end
    end

    // One-hot grant is the decode of the next grant_id gated by grant_valid.
    always_comb begin
        grant_s = {NO_OF_MASTERS{1'b0}};
        for (int m = 0; m < NO_OF_MASTERS; m++) begin
            grant_s[m] = grant_valid_s & (grant_id_s == MW'(m));
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_r       <= ARB_IDLE;
            grant_r       <= {NO_OF_MASTERS{1'b0}};
            grant_id_r    <= {MW{1'b0}};
            grant_valid_r <= 1'b0;
            dp_valid_r    <= 1'b0;
            dp_owner_r    <= {MW{1'b0}};
            rr_ptr_r      <= {MW{1'b0}};
            locked_r      <= 1'b0;
            lock_err_r    <= 1'b0;
            lock_cnt_r    <= {CW{1'b0}};
        end else begin
            state_r       <= state_s;
            grant_r       <= grant_s;
            grant_id_r    <= grant_id_s;
            grant_valid_r <= grant_valid_s;
            dp_valid_r    <= dp_valid_s;
            dp_owner_r    <= dp_owner_s;
            rr_ptr_r      <= rr_ptr_s;
            locked_r      <= (state_s == ARB_LOCK);
            lock_err_r    <= lock_err_s;
            lock_cnt_r    <= lock_cnt_s;
        end
    end

    assign grant       = grant_r;
    assign grant_id    = grant_id_r;
    assign grant_valid = grant_valid_r;
    assign dp_valid    = dp_valid_r;
    assign dp_owner    = dp_owner_r;
    assign locked      = locked_r;
    assign lock_err    = lock_err_r;

endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// Testbench for ahb_slave_port_arbiter (4 masters, LOCK_TIMEOUT=8).
// Directed vector table, a hand-written lock-timeout sequence, then
// randomized traffic checked against a behavioural model.
module tb_ahb_slave_port_arbiter;

    localparam int N  = 4;
    localparam int LT = 8;

    localparam logic [1:0] I  = 2'b00;
    localparam logic [1:0] B  = 2'b01;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [7:0]  m_htrans;
    logic [3:0]  m_hsel;
    logic [3:0]  m_hmastlock;
    logic        s_hreadyout;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        grant_valid;
    logic        dp_valid;
    logic [1:0]  dp_owner;
    logic        locked;
    logic        lock_err;

    int checks   = 0;
    int failures = 0;

    ahb_slave_port_arbiter #(.NO_OF_MASTERS(N), .LOCK_TIMEOUT(LT)) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .m_htrans    (m_htrans),
        .m_hsel      (m_hsel),
        .m_hmastlock (m_hmastlock),
        .s_hreadyout (s_hreadyout),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .dp_valid    (dp_valid),
        .dp_owner    (dp_owner),
        .locked      (locked),
        .lock_err    (lock_err)
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic       rst_n;
        logic [7:0] htrans;
        logic [3:0] hsel;
        logic [3:0] lock;
        logic       rdy;
        logic [3:0] e_grant;
        logic [1:0] e_id;
        logic       e_gv;
        logic       e_dpv;
        logic [1:0] e_dpo;
        logic       e_locked;
        logic       e_err;
    } vec_t;

    vec_t vt [0:20];

    function automatic vec_t mkv(logic r, logic [7:0] ht, logic [3:0] hs, logic [3:0] lk,
                                 logic rd, logic [3:0] g, logic [1:0] id, logic gv,
                                 logic dpv, logic [1:0] dpo, logic lkd, logic er);
        vec_t v;
        v.rst_n = r;  v.htrans = ht; v.hsel = hs; v.lock = lk; v.rdy = rd;
        v.e_grant = g; v.e_id = id; v.e_gv = gv; v.e_dpv = dpv; v.e_dpo = dpo;
        v.e_locked = lkd; v.e_err = er;
        return v;
    endfunction

    // {grant, grant_id, grant_valid, dp_valid, dp_owner, locked, lock_err}
    function automatic logic [11:0] outs();
        return {grant, grant_id, grant_valid, dp_valid, dp_owner, locked, lock_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         md_owner;   // -1 when no owner
    bit         md_inlock;
    int         md_rr;
    int         md_cnt;
    logic [3:0] e_grant;
    logic [1:0] e_id;
    logic       e_gv, e_dpv, e_locked, e_err;
    logic [1:0] e_dpo;

    // Two passes over the round-robin order: locked requesters, then anyone.
    function automatic int pick(logic [3:0] rq, logic [3:0] lk, int rr);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < N; i++) begin
                int idx;
                idx = (rr + i) % N;
                if (rq[idx] && (pass == 1 || lk[idx])) return idx;
            end
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [3:0] rq;
        logic [3:0] one;
        logic [1:0] ot;
        int  nown;
        bit  nlock;
        bit  arb;
        one = 4'b0001;
        if (!hresetn) begin
            md_owner = -1; md_inlock = 1'b0; md_rr = 0; md_cnt = 0;
            e_grant = 4'b0000; e_id = 2'd0; e_gv = 1'b0; e_dpv = 1'b0;
            e_dpo = 2'd0; e_locked = 1'b0; e_err = 1'b0;
            return;
        end
        e_err = 1'b0;
        if (!s_hreadyout) return;
        for (int m = 0; m < N; m++) rq[m] = m_hsel[m] && m_htrans[2*m+1];
        e_dpv = (md_owner >= 0) && rq[md_owner];
        e_dpo = (md_owner >= 0) ? 2'(md_owner) : 2'd0;
        nown  = md_owner;
        nlock = md_inlock;
        arb   = 1'b0;
        if (md_owner < 0) begin
            arb = 1'b1;
        end else begin
            ot = m_htrans[2*md_owner +: 2];
            if (md_inlock && m_hmastlock[md_owner]) nlock = 1'b1;
            else if (ot == SQ || ot == B)          nlock = 1'b0;
            else if (m_hmastlock[md_owner])        nlock = 1'b1;
            else                                   arb = 1'b1;
        end
        if (arb) begin
            nown = pick(rq, rq & m_hmastlock, md_rr);
            if (nown >= 0) begin
                nlock = m_hmastlock[nown];
                md_rr = (nown + 1) % N;
            end else begin
                nlock = 1'b0;
            end
        end
        if (md_inlock && nlock) begin
            if (md_cnt == LT - 1) e_err = 1'b1;
            if (md_cnt < LT) md_cnt++;
        end else begin
            md_cnt = 0;
        end
        md_owner  = nown;
        md_inlock = nlock;
        e_gv      = (nown >= 0);
        e_id      = e_gv ? 2'(nown) : 2'd0;
        e_grant   = e_gv ? (one << nown) : 4'b0000;
        e_locked  = nlock;
    endtask

    initial begin
        // rst htrans{m3,m2,m1,m0} hsel lock rdy | grant id gv dpv dpo locked err
        vt[0]  = mkv(1'b0, {I,I,I,NS},   4'b0001, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vt[1]  = mkv(1'b0, {I,I,I,NS},   4'b0001, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vt[2]  = mkv(1'b1, {I,I,I,NS},   4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        vt[3]  = mkv(1'b1, {I,I,I,NS},   4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        vt[4]  = mkv(1'b1, {I,NS,I,NS},  4'b0101, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        vt[5]  = mkv(1'b1, {I,NS,I,NS},  4'b0101, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
        vt[6]  = mkv(1'b1, {I,NS,I,NS},  4'b0101, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        vt[7]  = mkv(1'b1, {I,I,I,I},    4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
        vt[8]  = mkv(1'b1, {I,I,I,I},    4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vt[9]  = mkv(1'b1, {I,I,NS,I},   4'b0010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        vt[10] = mkv(1'b1, {NS,I,SQ,I},  4'b1010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        vt[11] = mkv(1'b1, {NS,I,SQ,I},  4'b1010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        vt[12] = mkv(1'b1, {NS,I,SQ,I},  4'b1010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        vt[13] = mkv(1'b1, {NS,I,I,I},   4'b1000, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        vt[14] = mkv(1'b1, {I,NS,I,I},   4'b0100, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        vt[15] = mkv(1'b1, {I,NS,I,I},   4'b0100, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        vt[16] = mkv(1'b1, {I,NS,I,I},   4'b0100, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        vt[17] = mkv(1'b1, {I,NS,I,I},   4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
        vt[18] = mkv(1'b1, {I,SQ,I,NS},  4'b0101, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
        vt[19] = mkv(1'b0, {I,SQ,I,NS},  4'b0101, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        vt[20] = mkv(1'b1, {NS,I,NS,I},  4'b1010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);

        for (int i = 0; i < 21; i++) begin
            hresetn     = vt[i].rst_n;
            m_htrans    = vt[i].htrans;
            m_hsel      = vt[i].hsel;
            m_hmastlock = vt[i].lock;
            s_hreadyout = vt[i].rdy;
            @(posedge hclk);
            #1;
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'({vt[i].e_grant, vt[i].e_id, vt[i].e_gv, vt[i].e_dpv,
                       vt[i].e_dpo, vt[i].e_locked, vt[i].e_err}));
        end

        // Locked sequence by m2 while m0/m1 request; timeout pulse after 8 locked ready cycles.
        hresetn = 1'b0;
        @(posedge hclk);
        #1;
        check("lock_rst", 32'(outs()), 32'd0);
        hresetn     = 1'b1;
        m_htrans    = {I,NS,NS,NS};
        m_hsel      = 4'b0111;
        m_hmastlock = 4'b0100;
        s_hreadyout = 1'b1;
        @(posedge hclk);
        #1;
        check("lock_grant", 32'({grant, locked, lock_err}), 32'({4'b0100, 1'b1, 1'b0}));
        for (int k = 1; k <= 12; k++) begin
            @(posedge hclk);
            #1;
            check($sformatf("lock_hold%0d", k), 32'({grant, locked, lock_err}),
                  32'({4'b0100, 1'b1, logic'(k == 8)}));
        end
        m_htrans    = {I,I,NS,NS};
        m_hsel      = 4'b0011;
        m_hmastlock = 4'b0000;
        @(posedge hclk);
        #1;
        check("lock_release", 32'({grant, grant_id, locked}), 32'({4'b0001, 2'd0, 1'b0}));

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            hresetn = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 1) == 0) begin
                m_htrans = 8'($urandom);
                m_hsel   = 4'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                m_hmastlock = 4'($urandom) & 4'($urandom);
            end
            s_hreadyout = ($urandom_range(0, 4) != 0);
            model_step();
            @(posedge hclk);
            #1;
            check($sformatf("rand%0d", c), 32'(outs()),
                  32'({e_grant, e_id, e_gv, e_dpv, e_dpo, e_locked, e_err}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
